// File: rtl/rv32im_pkg.sv
// rv32im_pkg: shared constants for the fetch stage: NOP encoding, reset vector, FSM states.
package rv32im_pkg;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR    = 32'h0000_0000;
    localparam logic [0:0]  FETCH           = 1'b0;
    localparam logic [0:0]  HELD            = 1'b1;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory read bus between fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;
    logic        read;
    logic [31:0] address;
    logic [31:0] readdata;
    logic        busywait;
    modport master (output read, address, input readdata, busywait);
    modport slave  (input read, address, output readdata, busywait);
endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// if_id_register: IF/ID pipeline register with flush (bubble) taking priority over load; otherwise holds.
module if_id_register
    import rv32im_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] word,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= NOP_INSTRUCTION;
            pc_out      <= RESET_VECTOR;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_INSTRUCTION;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= word;
            pc_out      <= pc;
            valid       <= 1'b1;
        end
    end
    assign pc_plus4 = pc_out + 32'd4;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: two-state fetch FSM with stall hold buffer and deferred redirect.
// Optional IFU_PERF_CNT_EN adds fetch_count/discard_count outputs.
module instruction_fetch_unit
    import rv32im_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_target,
    instruction_fetch_unit_if.master  imem,
    output logic [31:0]               instruction,
    output logic [31:0]               pc_out,
    output logic [31:0]               pc_plus4,
    output logic                      valid
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]               fetch_count,
    output logic [31:0]               discard_count
`endif
);
    logic [0:0]  state;
    logic [31:0] pc, buffer, target, tgt;
    logic        pending, held, done, load, flush, discard;

    always_comb begin
        tgt     = {branch_target[31:2], 2'b00};
        held    = state == HELD;
        done    = !held && !imem.busywait;
        flush   = branch_taken || (!held && !stall && (imem.busywait || pending));
        load    = !branch_taken && !stall && (held || (!imem.busywait && !pending));
        discard = branch_taken ? (held || done) : (done && pending);
    end

    assign imem.read    = !rst && !held;
    assign imem.address = pc;

    // A redirect during a busy access is deferred so the address stays stable until completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_VECTOR;
            state   <= FETCH;
            buffer  <= '0;
            target  <= '0;
            pending <= 1'b0;
        end else if (held) begin
            if (branch_taken) begin
                pc    <= tgt;
                state <= FETCH;
            end else if (!stall) begin
                pc    <= pc + 32'd4;
                state <= FETCH;
            end
        end else if (imem.busywait) begin
            if (branch_taken) begin
                target  <= tgt;
                pending <= 1'b1;
            end
        end else begin
            pending <= 1'b0;
            if (branch_taken)
                pc <= tgt;
            else if (pending)
                pc <= target;
            else if (stall) begin
                buffer <= imem.readdata;
                state  <= HELD;
            end else
                pc <= pc + 32'd4;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count   <= '0;
            discard_count <= '0;
        end else begin
            fetch_count   <= fetch_count + 32'(load);
            discard_count <= discard_count + 32'(discard);
        end
    end
`endif

    if_id_register u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .word        (held ? buffer : imem.readdata),
        .pc          (pc),
        .instruction (instruction),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .valid       (valid)
    );
endmodule
